// File: rtl/sha256_pad_pkg.sv
// Shared types, constants and helpers for the SHA-256 message padder.
package sha256_pad_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PAD,
        S_WAIT_CORE,
        S_SEND,
        S_DONE
    } state_e;

    localparam logic [4:0]  BLK_WORDS  = 5'd16;
    localparam logic [4:0]  LEN_HI_IDX = 5'd14;
    localparam logic [4:0]  LEN_LO_IDX = 5'd15;
    localparam logic [31:0] PAD_WORD   = 32'h8000_0000;

    function automatic logic [2:0] last_nbytes(input logic [1:0] b);
        return (b == 2'd0) ? 3'd4 : {1'b0, b};
    endfunction

    // Zero the unused low bytes and drop the 0x80 marker right after the data
    function automatic logic [31:0] pad_last(input logic [31:0] d,
                                             input logic [1:0]  b);
        logic [31:0] r;
        unique case (b)
            2'd1:    r = {d[31:24], 8'h80, 16'h0000};
            2'd2:    r = {d[31:16], 8'h80, 8'h00};
            2'd3:    r = {d[31:8], 8'h80};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha256_blk_buf.sv
// 16x32 block buffer with sequential write index and registered read port.
module sha256_blk_buf
    import sha256_pad_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic        wclr_i,
    input  logic        rd_en_i,
    output logic [4:0]  wr_idx_o,
    output logic [3:0]  rd_idx_o,
    output logic [31:0] rdata_o
);

    logic [31:0] mem_q [0:15];
    logic [4:0]  wr_idx_q, wr_idx_d;
    logic [3:0]  rd_idx_q, rd_idx_d;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        wr_idx_d = wr_idx_q;
        if (wclr_i) begin
            wr_idx_d = '0;
        end else if (we_i && wr_idx_q != BLK_WORDS) begin
            wr_idx_d = wr_idx_q + 5'd1;
        end
    end

    always_comb begin
        rd_idx_d = rd_idx_q;
        rdata_d  = rdata_q;
        if (rd_en_i) begin
            rd_idx_d = rd_idx_q + 4'd1;
            rdata_d  = mem_q[rd_idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (we_i && wr_idx_q != BLK_WORDS) begin
            mem_q[wr_idx_q[3:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            rdata_q  <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            rdata_q  <= rdata_d;
        end
    end

    assign wr_idx_o = wr_idx_q;
    assign rd_idx_o = rd_idx_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: buffers words, appends 0x80/zero/length padding and
// bursts 16-word blocks to the core. SHA256_PAD_BLKCNT_EN adds blk_cnt_o.
module sha256_msg_padder
    import sha256_pad_pkg::*;
#(
    parameter int LEN_W   = 32,
    parameter int GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [31:0] s_data_i,
    input  logic        s_last_i,
    input  logic [1:0]  s_bytes_i,
    input  logic        core_idle_i,
    output logic        m_valid_o,
    output logic [31:0] m_data_o,
`ifdef SHA256_PAD_BLKCNT_EN
    output logic [15:0] blk_cnt_o,
`endif
    output logic        msg_done_o
);

    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             pad80_q, pad80_d;
    logic             tail_q, tail_d;
    logic             final_q, final_d;
    logic             len_hi_q, len_hi_d;
    logic             rdy_q, rdy_d;
    logic             m_valid_q, m_valid_d;
    logic [GW-1:0]    gap_q, gap_d;

    logic        buf_we, buf_clr, rd_en;
    logic [31:0] buf_wdata, rdata;
    logic [4:0]  wr_idx;
    logic [3:0]  rd_idx;
    logic [63:0] bit_len;
    logic        send_last;

    assign bit_len   = 64'({byte_cnt_q, 3'b000});
    assign send_last = (state_q == S_SEND) && (rd_idx == 4'd0);

    sha256_blk_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (buf_we),
        .wdata_i  (buf_wdata),
        .wclr_i   (buf_clr),
        .rd_en_i  (rd_en),
        .wr_idx_o (wr_idx),
        .rd_idx_o (rd_idx),
        .rdata_o  (rdata)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        pad80_d    = pad80_q;
        tail_d     = tail_q;
        final_d    = final_q;
        len_hi_d   = len_hi_q;
        gap_d      = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        buf_we     = 1'b0;
        buf_wdata  = '0;
        buf_clr    = 1'b0;
        rd_en      = 1'b0;
        m_valid_d  = 1'b0;
        unique case (state_q)
            S_IDLE, S_FILL: begin
                if (s_valid_i && rdy_q) begin
                    buf_we = 1'b1;
                    if (s_last_i) begin
                        buf_wdata  = pad_last(s_data_i, s_bytes_i);
                        byte_cnt_d = byte_cnt_q
                                   + LEN_W'(last_nbytes(s_bytes_i));
                        pad80_d    = (s_bytes_i == 2'd0);
                        tail_d     = 1'b1;
                        state_d    = S_PAD;
                    end else begin
                        buf_wdata  = s_data_i;
                        byte_cnt_d = byte_cnt_q + LEN_W'(4);
                        state_d    = (wr_idx == LEN_LO_IDX) ? S_WAIT_CORE
                                                            : S_FILL;
                        final_d    = 1'b0;
                    end
                end
            end
            S_PAD: begin
                if (wr_idx == BLK_WORDS) begin
                    final_d = 1'b0;
                    state_d = S_WAIT_CORE;
                end else begin
                    buf_we = 1'b1;
                    if (pad80_q) begin
                        buf_wdata = PAD_WORD;
                        pad80_d   = 1'b0;
                    end else if (wr_idx == LEN_HI_IDX) begin
                        buf_wdata = bit_len[63:32];
                        len_hi_d  = 1'b1;
                    end else if (wr_idx == LEN_LO_IDX && len_hi_q) begin
                        buf_wdata = bit_len[31:0];
                        len_hi_d  = 1'b0;
                        final_d   = 1'b1;
                    end else begin
                        buf_wdata = '0;
                    end
                    // Writing slot 15 always completes the buffer
                    if (wr_idx == LEN_LO_IDX) begin
                        state_d = S_WAIT_CORE;
                    end
                end
            end
            S_WAIT_CORE: begin
                if (gap_q == '0 && core_idle_i) begin
                    rd_en     = 1'b1;
                    m_valid_d = 1'b1;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (send_last) begin
                    buf_clr = 1'b1;
                    gap_d   = GW'(GAP_CYC);
                    if (final_q) begin
                        state_d = S_DONE;
                    end else if (tail_q) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    rd_en     = 1'b1;
                    m_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                byte_cnt_d = '0;
                tail_d     = 1'b0;
                final_d    = 1'b0;
                pad80_d    = 1'b0;
                len_hi_d   = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rdy_d = (state_d == S_IDLE) || (state_d == S_FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            pad80_q    <= 1'b0;
            tail_q     <= 1'b0;
            final_q    <= 1'b0;
            len_hi_q   <= 1'b0;
            rdy_q      <= 1'b0;
            m_valid_q  <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pad80_q    <= pad80_d;
            tail_q     <= tail_d;
            final_q    <= final_d;
            len_hi_q   <= len_hi_d;
            rdy_q      <= rdy_d;
            m_valid_q  <= m_valid_d;
            gap_q      <= gap_d;
        end
    end

`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
        end else if (state_q == S_DONE) begin
            blk_cnt_q <= '0;
        end else if (send_last) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign blk_cnt_o = blk_cnt_q;
`endif

    assign s_ready_o  = rdy_q;
    assign m_valid_o  = m_valid_q;
    assign m_data_o   = rdata;
    assign msg_done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: reference padding model feeds a
// scoreboard queue checked against every burst word.
module tb_sha256_msg_padder;

    localparam int GAP_CYC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready_o;
    logic [31:0] s_data;
    logic        s_last;
    logic [1:0]  s_bytes;
    logic        core_idle;
    logic        m_valid_o;
    logic [31:0] m_data_o;
    logic        msg_done_o;
`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0] blk_cnt_o;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got [0:4095];
    int          got_n = 0;
    int          done_cnt = 0;
    int          bursts = 0;
    int          run = 0;
    int          idle_cnt = 0;
    bit          mon_en = 1'b1;
    logic [7:0]  mb [0:255];
    int          base;
    int          d0;

    sha256_msg_padder #(.LEN_W(32), .GAP_CYC(GAP_CYC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .s_bytes_i   (s_bytes),
        .core_idle_i (core_idle),
        .m_valid_o   (m_valid_o),
        .m_data_o    (m_data_o),
`ifdef SHA256_PAD_BLKCNT_EN
        .blk_cnt_o   (blk_cnt_o),
`endif
        .msg_done_o  (msg_done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference padding: bytes, 0x80, zeros to 56 mod 64, 64-bit bit length
    task automatic push_expected(input int L);
        int          total;
        logic [63:0] bl;
        logic [7:0]  p;
        logic [31:0] wd;
        total = ((L + 8) / 64 + 1) * 64;
        bl    = 64'(L) * 64'd8;
        wd    = '0;
        for (int i = 0; i < total; i++) begin
            if (i < L) p = mb[i];
            else if (i == L) p = 8'h80;
            else if (i >= total - 8) p = bl[8*(total-1-i) +: 8];
            else p = 8'h00;
            wd = {wd[23:0], p};
            if (i % 4 == 3) exp_q.push_back(wd);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l,
                             input logic [1:0] b);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        s_bytes = b;
        t = 0;
        while (!s_ready_o && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", 32'(t < 2000), 1);
        @(negedge clk);
    endtask

    task automatic drive_msg(input int L, input logic [7:0] junk);
        int          nw;
        logic [31:0] d;
        nw = (L + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            d = '0;
            for (int k = 0; k < 4; k++) begin
                d = {d[23:0], (4*w + k < L) ? mb[4*w + k] : junk};
            end
            send_word(d, w == nw - 1, 2'(L % 4));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 32'(done_cnt - d0), 1);
        @(negedge clk);
        chk("done_one_cycle", msg_done_o, 0);
        repeat (3) @(negedge clk);
        chk("done_once", 32'(done_cnt - d0), 1);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    task automatic run_msg(input int L, input logic [7:0] junk);
        base = got_n;
        d0   = done_cnt;
        push_expected(L);
        drive_msg(L, junk);
        wait_done();
    endtask

    task automatic set_pattern(input int L);
        for (int i = 0; i < L; i++) mb[i] = 8'(i + 1);
    endtask

    task automatic set_abc();
        mb[0] = 8'h61;
        mb[1] = 8'h62;
        mb[2] = 8'h63;
    endtask

    // Output monitor: scoreboard pops, burst length, inter-burst gap, done pulse
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run    = 0;
                bursts = 0;
            end else if (mon_en) begin
                if (m_valid_o) begin
                    if (run == 0 && bursts > 0)
                        chk("burst_gap", 32'(idle_cnt >= GAP_CYC), 1);
                    run++;
                    chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0)
                        chk("blk_word", m_data_o, exp_q.pop_front());
                    if (got_n < 4096) got[got_n] = m_data_o;
                    got_n++;
                    chk("no_ready_in_send", s_ready_o, 0);
                    idle_cnt = 0;
                end else begin
                    if (run != 0) begin
                        chk("burst_len", run, 16);
                        run = 0;
                        bursts++;
                    end
                    idle_cnt++;
                end
                if (msg_done_o) begin
                    done_cnt++;
                    chk("done_after_burst", exp_q.size(), 0);
`ifdef SHA256_PAD_BLKCNT_EN
                    chk("blk_cnt", blk_cnt_o, bursts);
`endif
                    bursts = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int lens [11] = '{1, 2, 4, 5, 52, 60, 63, 65, 119, 120, 130};
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        s_bytes   = '0;
        core_idle = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready_o, 0);
        chk("rst_m_valid", m_valid_o, 0);
        chk("rst_m_data", m_data_o, 0);
        chk("rst_done", msg_done_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_s_ready", s_ready_o, 1);

        set_abc();
        run_msg(3, 8'h00);
        chk("abc_nwords", got_n - base, 16);
        chk("abc_w0", got[base], 32'h6162_6380);
        chk("abc_w7", got[base+7], 32'h0);
        chk("abc_w15", got[base+15], 32'h0000_0018);

        set_pattern(55);
        run_msg(55, 8'hA5);
        chk("b55_nwords", got_n - base, 16);
        chk("b55_w13", got[base+13], 32'h3536_3780);
        chk("b55_w14", got[base+14], 32'h0);
        chk("b55_w15", got[base+15], 32'h0000_01B8);

        set_pattern(56);
        run_msg(56, 8'h5A);
        chk("b56_nwords", got_n - base, 32);
        chk("b56_b1_w14", got[base+14], 32'h8000_0000);
        chk("b56_b1_w15", got[base+15], 32'h0);
        chk("b56_b2_w0", got[base+16], 32'h0);
        chk("b56_b2_w15", got[base+31], 32'h0000_01C0);

        set_pattern(64);
        run_msg(64, 8'h33);
        chk("b64_nwords", got_n - base, 32);
        chk("b64_b1_w0", got[base], 32'h0102_0304);
        chk("b64_b1_w15", got[base+15], 32'h3D3E_3F40);
        chk("b64_b2_w0", got[base+16], 32'h8000_0000);
        chk("b64_b2_w15", got[base+31], 32'h0000_0200);

        // Core busy: block held until core_idle rises
        set_pattern(8);
        core_idle = 1'b0;
        base = got_n;
        d0   = done_cnt;
        push_expected(8);
        drive_msg(8, 8'hEE);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("bp_m_valid", m_valid_o, 0);
            chk("bp_s_ready", s_ready_o, 0);
        end
        core_idle = 1'b1;
        wait_done();
        chk("bp_nwords", got_n - base, 16);

        // Asynchronous reset in the middle of a burst
        mon_en = 1'b0;
        exp_q.delete();
        set_abc();
        drive_msg(3, 8'h00);
        t = 0;
        while (!m_valid_o && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("rst_burst_start", m_valid_o, 1);
        repeat (7) @(negedge clk);
        chk("rst_mid_valid", m_valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", m_valid_o, 0);
        chk("rst_async_data", m_data_o, 0);
        @(negedge clk);
        chk("rst_next_valid", m_valid_o, 0);
        chk("rst_next_ready", s_ready_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        set_abc();
        run_msg(3, 8'h00);
        chk("rabc_nwords", got_n - base, 16);
        chk("rabc_w0", got[base], 32'h6162_6380);
        chk("rabc_w15", got[base+15], 32'h0000_0018);

        foreach (lens[i]) begin
            for (int k = 0; k < lens[i]; k++) mb[k] = 8'($urandom);
            run_msg(lens[i], 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
